// File: rtl/alu_32.sv
// Registered 32-bit ALU: AND/OR/ADD/SUB/SLT plus AND-NOT/OR-NOT, with overflow and zero flags.
// Define ALU_CARRY_OUT_EN to add the registered adder carry-out port.
module alu_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             overflow,
`ifdef ALU_CARRY_OUT_EN
  output logic             carry,
`endif
  output logic             zero,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [2:0] {
    FN_AND   = 3'b000,
    FN_OR    = 3'b001,
    FN_ADD   = 3'b010,
    FN_RSVD  = 3'b011,
    FN_ANDN  = 3'b100,
    FN_ORN   = 3'b101,
    FN_SUB   = 3'b110,
    FN_SLT   = 3'b111
  } alu_fn_e;

  alu_fn_e          w_fn;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_y;
  logic             w_ovf;

  logic [WIDTH-1:0] r_y;
  logic             r_ovf;
  logic             r_zero;

  assign w_fn = alu_fn_e'(f);
  assign w_bb = f[2] ? ~b : b;

`ifdef ALU_CARRY_OUT_EN
  logic w_cout;
  logic w_carry;
  logic r_carry;
  assign {w_cout, w_sum} = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, f[2]};
`else
  assign w_sum = a + w_bb + {{(WIDTH-1){1'b0}}, f[2]};
`endif

  // Same overflow term serves ADD/SUB reporting and the SLT sign correction.
  assign w_add_ovf = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_lt      = w_sum[WIDTH-1] ^ w_add_ovf;

  always_comb begin
    w_y   = '0;
    w_ovf = 1'b0;
`ifdef ALU_CARRY_OUT_EN
    w_carry = 1'b0;
`endif
    case (w_fn)
      FN_AND:  w_y = a & b;
      FN_OR:   w_y = a | b;
      FN_ANDN: w_y = a & w_bb;
      FN_ORN:  w_y = a | w_bb;
      FN_ADD, FN_SUB: begin
        w_y   = w_sum;
        w_ovf = w_add_ovf;
`ifdef ALU_CARRY_OUT_EN
        w_carry = w_cout;
`endif
      end
      FN_SLT:  w_y = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_y    <= w_y;
      r_ovf  <= w_ovf;
      r_zero <= (w_y == '0);
    end
  end

`ifdef ALU_CARRY_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) r_carry <= 1'b0;
    else       r_carry <= w_carry;
  end
  assign carry = r_carry;
`endif

  assign y        = r_y;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32; expected values are hand-computed constants.
module tb_alu_32;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  f;
  logic        overflow;
  logic        zero;
  logic [31:0] y;
`ifdef ALU_CARRY_OUT_EN
  logic        carry;
`endif

  int unsigned n_cmp;
  int unsigned n_bad;

  alu_32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .f        (f),
    .overflow (overflow),
`ifdef ALU_CARRY_OUT_EN
    .carry    (carry),
`endif
    .zero     (zero),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic [2:0] tf, input logic trst);
    a     = ta;
    b     = tb_v;
    f     = tf;
    reset = trst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] ey,
                            input logic eov, input logic ez);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eov});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    a = '0; b = '0; f = '0; reset = 1'b1;

    // Reset held two cycles while an overflowing ADD is presented
    step(32'h7FFFFFFF, 32'h1, 3'b010, 1'b1);
    step(32'h7FFFFFFF, 32'h1, 3'b010, 1'b1);
    expect_all("reset", 32'h0, 1'b0, 1'b1);
`ifdef ALU_CARRY_OUT_EN
    chk("reset.carry", {31'd0, carry}, 32'd0);
`endif

    step(32'd1, 32'd2, 3'b010, 1'b0);
    expect_all("add_1_2", 32'd3, 1'b0, 1'b0);
    step(32'd150000, 32'd5555, 3'b010, 1'b0);
    expect_all("add_big", 32'd155555, 1'b0, 1'b0);
    step(32'd128, 32'd128, 3'b110, 1'b0);
    expect_all("sub_eq", 32'd0, 1'b0, 1'b1);
    step(32'h40000000, 32'h40000000, 3'b010, 1'b0);
    expect_all("add_ovf", 32'h80000000, 1'b1, 1'b0);
    step(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0);
    expect_all("add_max_ovf", 32'h80000000, 1'b1, 1'b0);
    step(32'h80000000, 32'h00000001, 3'b110, 1'b0);
    expect_all("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b0);
    step(32'd1, 32'd2, 3'b110, 1'b0);
    expect_all("sub_neg", 32'hFFFFFFFF, 1'b0, 1'b0);
`ifdef ALU_CARRY_OUT_EN
    chk("sub_neg.carry", {31'd0, carry}, 32'd0);
`endif
    step(32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0);
    expect_all("add_wrap", 32'h0, 1'b0, 1'b1);
`ifdef ALU_CARRY_OUT_EN
    chk("add_wrap.carry", {31'd0, carry}, 32'd1);
`endif

    step(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b0);
    expect_all("and", 32'hF000F000, 1'b0, 1'b0);
`ifdef ALU_CARRY_OUT_EN
    chk("and.carry", {31'd0, carry}, 32'd0);
`endif
    step(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 1'b0);
    expect_all("or", 32'hFFF0FFF0, 1'b0, 1'b0);
    step(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b0);
    expect_all("andn", 32'h00F000F0, 1'b0, 1'b0);
    step(32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 1'b0);
    expect_all("orn", 32'hF0FFF0FF, 1'b0, 1'b0);
    step(32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 1'b0);
    expect_all("rsvd", 32'h0, 1'b0, 1'b1);

    step(32'h80000000, 32'h00000001, 3'b111, 1'b0);
    expect_all("slt_minint", 32'd1, 1'b0, 1'b0);
    step(32'd5, 32'd5, 3'b111, 1'b0);
    expect_all("slt_eq", 32'd0, 1'b0, 1'b1);
    step(32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0);
    expect_all("slt_max_vs_m1", 32'd0, 1'b0, 1'b1);
    step(32'hFFFFFFFF, 32'h7FFFFFFF, 3'b111, 1'b0);
    expect_all("slt_m1_vs_max", 32'd1, 1'b0, 1'b0);
    step(32'd3, 32'd7, 3'b111, 1'b0);
    expect_all("slt_small", 32'd1, 1'b0, 1'b0);

    // Mid-stream reset: nonzero result first, then reset overrides an ADD
    step(32'd10, 32'd20, 3'b010, 1'b0);
    expect_all("pre_reset", 32'd30, 1'b0, 1'b0);
    step(32'h40000000, 32'h40000000, 3'b010, 1'b1);
    expect_all("mid_reset", 32'h0, 1'b0, 1'b1);
    step(32'd7, 32'd9, 3'b010, 1'b0);
    expect_all("post_reset", 32'd16, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
